// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle unsigned MULTU/DIVU sequencer that borrows the shared ALU add/sub path
module mdu_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_f,
  input  logic [31:0] alu_y,
  input  logic        alu_c
);

  localparam int CW = $clog2(ITER);
  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [31:0]     h_q, l_q, m_q;
  logic            op_q;
  logic [CW-1:0]   cnt;
  logic [31:0]     s_rem;
  logic            take;

  // Remainder shifted left by one with the next dividend bit; H[31] is the bit that falls off.
  assign s_rem = {h_q[30:0], l_q[31]};
  assign take  = h_q[31] | alu_c;

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign hi   = h_q;
  assign lo   = l_q;

  always_comb begin
    state_n = state;
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    alu_f   = F_AND;
    case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (op_q) begin
          alu_a = s_rem;
          alu_b = m_q;
          alu_f = F_SUB;
        end else begin
          alu_a = h_q;
          alu_b = l_q[0] ? m_q : 32'd0;
          alu_f = F_ADD;
        end
        if (cnt == CW'(ITER - 1)) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      h_q   <= 32'd0;
      l_q   <= 32'd0;
      m_q   <= 32'd0;
      op_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            h_q  <= 32'd0;
            l_q  <= src_a;
            m_q  <= src_b;
            op_q <= op;
            cnt  <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (op_q) begin
            h_q <= take ? alu_y : s_rem;
            l_q <= {l_q[30:0], take};
          end else begin
            // 65-bit {carry, sum, L} shifted right by one
            h_q <= {alu_c, alu_y[31:1]};
            l_q <= {alu_y[0], l_q[31:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed self-checking bench for mdu_seq with a behavioural ALU
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_f;
  logic        alu_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_seq #(.ITER(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .alu_a (alu_a),
    .alu_b (alu_b),
    .alu_f (alu_f),
    .alu_y (alu_y),
    .alu_c (alu_c)
  );

  // Shared ALU stand-in: add, a + ~b + 1, otherwise AND.
  always_comb begin
    alu_y = alu_a & alu_b;
    alu_c = 1'b0;
    case (alu_f)
      3'b010: {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110: {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Launch one operation and watch a 36-cycle window; spurious starts may be injected
  // on negedge indices sp0/sp1 (0 = none). Index n counts negedges after the launch edge.
  task automatic run_op(input string name, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input int sp0, input int sp1, input logic [31:0] ehi, input logic [31:0] elo);
    int done_cnt;
    int done_at;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    done_cnt = 0;
    done_at  = 0;
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == sp0 || n == sp1) begin
        start = 1'b1; op = ~o; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0003;
      end
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (n == 1) begin
        check({name, "_busy_rise"}, 64'(busy), 64'd1);
        check({name, "_alu_f"}, 64'(alu_f), o ? 64'd6 : 64'd2);
      end
      if (n == 33) check({name, "_busy_done"}, 64'(busy), 64'd1);
      if (n == 34) check({name, "_busy_fall"}, 64'(busy), 64'd0);
    end
    start = 1'b0;
    check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({name, "_latency"}, 64'(done_at), 64'd33);
    check({name, "_busy_end"}, 64'(busy), 64'd0);
    check({name, "_hi"}, 64'(hi), 64'(ehi));
    check({name, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_alu", {alu_a, alu_b}, 64'd0);
    check("rst_alu_f", 64'(alu_f), 64'd0);

    // Reset and start together: reset wins.
    start = 1'b1; op = 1'b0; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    check("rst_start_busy", 64'(busy), 64'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_start_idle", 64'(busy), 64'd0);

    run_op("mul_small", 1'b0, 32'd3, 32'd5, 0, 0, 32'd0, 32'd15);
    check("hold_hilo", {hi, lo}, 64'd15);
    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14);
    run_op("div_ov", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 32'h7FFF_FFFF, 32'd1);
    run_op("div_zero", 1'b1, 32'd1234, 32'd0, 0, 0, 32'd1234, 32'hFFFF_FFFF);
    run_op("busy_start", 1'b1, 32'd100, 32'd7, 11, 33, 32'd2, 32'd14);

    // Abort mid-RUN: rst sampled at the edge ending RUN cycle 16.
    @(negedge clk);
    start = 1'b1; op = 1'b0; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk);
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    run_op("mul_7_9", 1'b0, 32'd7, 32'd9, 0, 0, 32'd0, 32'd63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
